// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, response, ALU and debug signals between host, sequencer and ALU.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ldi;
    logic [1:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    modport master (
        output cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output rsp_ready, alu_res, dbg_addr,
        input  cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_zero, dbg_data
    );
    modport slave (
        input  cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  rsp_ready, alu_res, dbg_addr,
        output cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_zero, dbg_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs LDI/ALU commands against a small register file and an external combinational ALU.
module alu_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int REG_AW = 2
) (
    input logic clk,
    input logic rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;
    state_t state, next;
    logic [DATA_W-1:0] regs [NREG];
    logic              ldi;
    logic [1:0]        op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] wb;
    logic              accept;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign wb            = ldi ? imm : bus.alu_res;
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.dbg_data  = regs[bus.dbg_addr];
    always_comb begin
        next = state;
        next = (state == IDLE) ? (accept ? (bus.cmd_ldi ? EXEC : READ) : IDLE) :
               (state == READ) ? EXEC :
               (state == EXEC) ? RESP :
               (bus.rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= 2'b00;
            bus.rsp_data <= '0;
            bus.rsp_zero <= 1'b0;
            ldi          <= 1'b0;
            op           <= 2'b00;
            rd           <= '0;
            rs1          <= '0;
            rs2          <= '0;
            imm          <= '0;
        end else begin
            state <= next;
            if (accept) begin
                ldi <= bus.cmd_ldi;
                op  <= bus.cmd_op;
                rd  <= bus.cmd_rd;
                rs1 <= bus.cmd_rs1;
                rs2 <= bus.cmd_rs2;
                imm <= bus.cmd_imm;
            end
            // operands captured before write-back, so rd aliasing rs1/rs2 sees the old value
            if (state == READ) begin
                bus.alu_a    <= regs[rs1];
                bus.alu_b    <= regs[rs2];
                bus.alu_ctrl <= op;
            end
            if (state == EXEC) begin
                regs[rd]     <= wb;
                bus.rsp_data <= wb;
                bus.rsp_zero <= (wb == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of command/response timing, ALU results, backpressure and reset abort.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    alu_op_sequencer_if #(.DATA_W(8), .REG_AW(2)) bus ();
    alu_op_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    // stand-in for the combinational ALU
    assign bus.alu_res = (bus.alu_ctrl == 2'b00) ? bus.alu_a + bus.alu_b :
                         (bus.alu_ctrl == 2'b01) ? bus.alu_a - bus.alu_b :
                         (bus.alu_ctrl == 2'b10) ? bus.alu_a & bus.alu_b :
                                                   bus.alu_a | bus.alu_b;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic dbg(input logic [1:0] addr, input logic [7:0] exp);
        bus.dbg_addr = addr;
        #1;
        chk($sformatf("dbg_r%0d", addr), bus.dbg_data, exp);
    endtask
    task automatic issue(input logic ldi, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [7:0] imm, input logic [7:0] exp);
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ldi   = ldi;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_ldi   = ~ldi;
        bus.cmd_op    = ~op;
        bus.cmd_rd    = ~rd;
        bus.cmd_imm   = 8'hA5;
        chk("rsp_valid_c1", bus.rsp_valid, 0);
        @(negedge clk);
        chk("rsp_valid_c2", bus.rsp_valid, {31'd0, ldi});
        if (!ldi) begin
            chk("alu_ctrl_exec", bus.alu_ctrl, {30'd0, op});
            @(negedge clk);
            chk("rsp_valid_c3", bus.rsp_valid, 1);
        end
        chk("rsp_data", bus.rsp_data, exp);
        chk("rsp_zero", bus.rsp_zero, {31'd0, exp == 8'h00});
        dbg(rd, exp);
    endtask
    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.rsp_valid, 0);
        chk("cmd_ready_after_hs", bus.cmd_ready, 1);
    endtask
    task automatic run(input logic ldi, input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [7:0] imm, input logic [7:0] exp);
        issue(ldi, op, rd, rs1, rs2, imm, exp);
        finish_rsp();
    endtask
    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_ldi = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_rd = 2'd0;
        bus.cmd_rs1 = 2'd0;
        bus.cmd_rs2 = 2'd0;
        bus.cmd_imm = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.dbg_addr = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_zero", bus.rsp_zero, 0);
        chk("reset_alu_a", bus.alu_a, 0);
        chk("reset_alu_b", bus.alu_b, 0);
        chk("reset_alu_ctrl", bus.alu_ctrl, 0);
        dbg(2'd3, 8'h00);
        rst = 1'b0;
        #1;
        chk("cmd_ready_release", bus.cmd_ready, 1);
        run(1, 2'b00, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05);
        run(1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03);
        dbg(2'd0, 8'h05);
        run(0, 2'b00, 2'd2, 2'd0, 2'd1, 8'h00, 8'h08);
        run(0, 2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 8'h02);
        run(0, 2'b10, 2'd2, 2'd0, 2'd1, 8'h00, 8'h01);
        run(0, 2'b11, 2'd2, 2'd0, 2'd1, 8'h00, 8'h07);
        run(1, 2'b00, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF);
        run(1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01);
        run(0, 2'b00, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00);
        run(1, 2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
        run(0, 2'b01, 2'd3, 2'd0, 2'd1, 8'h00, 8'hFF);
        run(1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03);
        run(0, 2'b00, 2'd1, 2'd1, 2'd1, 8'h00, 8'h06);
        run(0, 2'b00, 2'd1, 2'd1, 2'd1, 8'h00, 8'h0C);
        // r1=0C, r3=FF: add r2 = 0C+FF = 0B, held under backpressure
        issue(0, 2'b00, 2'd2, 2'd1, 2'd3, 8'h00, 8'h0B);
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = (i == 2);
            bus.cmd_ldi = 1'b1;
            bus.cmd_rd = 2'd0;
            bus.cmd_imm = 8'h55;
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_data", bus.rsp_data, 8'h0B);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        finish_rsp();
        dbg(2'd0, 8'h00);
        dbg(2'd2, 8'h0B);
        // abort add r2 = r1+r1 during EXEC
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ldi = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_rd = 2'd2;
        bus.cmd_rs1 = 2'd1;
        bus.cmd_rs2 = 2'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_alu_a_loaded", bus.alu_a, 8'h0C);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_rsp_zero", bus.rsp_zero, 0);
        chk("abort_alu_a", bus.alu_a, 0);
        chk("abort_alu_b", bus.alu_b, 0);
        chk("abort_alu_ctrl", bus.alu_ctrl, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 0);
        dbg(2'd2, 8'h00);
        dbg(2'd1, 8'h00);
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready_release", bus.cmd_ready, 1);
        run(1, 2'b00, 2'd3, 2'd0, 2'd0, 8'h42, 8'h42);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
